// File: rtl/data_mem_arbiter_if.sv
// CPU, DMA and memory-side signals of the data memory arbiter.
// slave: the arbiter's view. master: the requesters' and memory's view.
interface data_mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_ack;
    logic [15:0] dma_rdata;

    logic        mem_w_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output mem_w_en, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  mem_w_en, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU, DMA) request/acknowledge arbiter in front of a single-port synchronous
// data memory with a 1-cycle registered read. One access per IDLE -> ACCESS -> RESP pass.
// CPU has priority, but a run of CPU grants while DMA waits is capped at STARVE_LIMIT.
module data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input logic               sys_clock,
    input logic               sys_reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
    typedef enum logic {OwnCpu, OwnDma} owner_e;

    localparam logic [CNT_W-1:0] StreakMax = CNT_W'(STARVE_LIMIT);

    state_e             state_q;
    owner_e             owner_q;
    logic [CNT_W-1:0]   streak_q;
    logic [CNT_W-1:0]   streak_d;
    logic               mem_w_en_q;
    logic [15:0]        mem_addr_q;
    logic [15:0]        mem_wdata_q;
    logic               cpu_ack_q;
    logic               dma_ack_q;

    logic               any_req;
    logic               dma_wins;
    logic               grant_we;
    logic [15:0]        grant_addr;
    logic [15:0]        grant_wdata;

    // Winner selection, latched fields and next streak value; only consumed in StIdle.
    always_comb begin
        any_req     = bus.cpu_req | bus.dma_req;
        // The streak never exceeds StreakMax, so equality is the starvation test.
        dma_wins    = bus.dma_req & (~bus.cpu_req | (streak_q == StreakMax));
        grant_we    = dma_wins ? bus.dma_we    : bus.cpu_we;
        grant_addr  = dma_wins ? bus.dma_addr  : bus.cpu_addr;
        grant_wdata = dma_wins ? bus.dma_wdata : bus.cpu_wdata;
        streak_d    = '0;
        if (dma_wins || !bus.dma_req) begin
            streak_d = '0;
        end else if (streak_q == StreakMax) begin
            streak_d = streak_q;
        end else begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Arbitration FSM with registered memory controls and acks.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnCpu;
            streak_q    <= '0;
            mem_w_en_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        owner_q     <= dma_wins ? OwnDma : OwnCpu;
                        mem_w_en_q  <= grant_we;
                        mem_addr_q  <= grant_addr;
                        mem_wdata_q <= grant_wdata;
                        streak_q    <= streak_d;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    // Memory samples the access on this edge; address stays put.
                    mem_w_en_q <= 1'b0;
                    cpu_ack_q  <= (owner_q == OwnCpu);
                    dma_ack_q  <= (owner_q == OwnDma);
                    state_q    <= StResp;
                end
                StResp: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    cpu_ack_q  <= 1'b0;
                    dma_ack_q  <= 1'b0;
                    mem_w_en_q <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_w_en  = mem_w_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    // Read data passes straight through from memory, gated to the acked owner.
    assign bus.cpu_rdata = cpu_ack_q ? bus.mem_rdata : 16'h0000;
    assign bus.dma_rdata = dma_ack_q ? bus.mem_rdata : 16'h0000;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two lanes (STARVE_LIMIT 4 and 0) each with a memory model,
// driven by directed and random stimulus and compared every cycle against a
// transaction-level reference model.
module tb_data_mem_arbiter;
    localparam int NL = 2;
    localparam byte ChC = 8'h43;
    localparam byte ChD = 8'h44;

    logic sys_clock = 1'b0;
    logic sys_reset = 1'b1;
    always #5 sys_clock = ~sys_clock;

    logic        creq [NL];
    logic        cwe  [NL];
    logic [15:0] caddr[NL];
    logic [15:0] cwd  [NL];
    logic        dreq [NL];
    logic        dwe  [NL];
    logic [15:0] daddr[NL];
    logic [15:0] dwd  [NL];
    logic        cack [NL];
    logic        dack [NL];
    logic [15:0] crd  [NL];
    logic [15:0] drd  [NL];
    logic        mwe  [NL];
    logic [15:0] maddr[NL];
    logic [15:0] mwd  [NL];
    logic        bsy  [NL];

    function automatic int lim_of(input int l);
        return (l == 0) ? 4 : 0;
    endfunction

    function automatic logic [15:0] init_word(input logic [14:0] a);
        return (a == 15'h0010) ? 16'hBEEF : ({a, 1'b0} ^ 16'hA5C3);
    endfunction

    for (genvar gl = 0; gl < NL; gl++) begin : g_lane
        data_mem_arbiter_if lane_if ();
        logic [15:0] mem_q [32768];
        bit          wr_q  [32768];
        logic [15:0] rd_q;

        assign lane_if.cpu_req   = creq[gl];
        assign lane_if.cpu_we    = cwe[gl];
        assign lane_if.cpu_addr  = caddr[gl];
        assign lane_if.cpu_wdata = cwd[gl];
        assign lane_if.dma_req   = dreq[gl];
        assign lane_if.dma_we    = dwe[gl];
        assign lane_if.dma_addr  = daddr[gl];
        assign lane_if.dma_wdata = dwd[gl];
        assign lane_if.mem_rdata = rd_q;
        assign cack[gl]  = lane_if.cpu_ack;
        assign dack[gl]  = lane_if.dma_ack;
        assign crd[gl]   = lane_if.cpu_rdata;
        assign drd[gl]   = lane_if.dma_rdata;
        assign mwe[gl]   = lane_if.mem_w_en;
        assign maddr[gl] = lane_if.mem_addr;
        assign mwd[gl]   = lane_if.mem_wdata;
        assign bsy[gl]   = lane_if.busy;

        data_mem_arbiter #(.STARVE_LIMIT((gl == 0) ? 4 : 0)) u_dut (
            .sys_clock (sys_clock),
            .sys_reset (sys_reset),
            .bus       (lane_if.slave)
        );

        // Single-port memory, 15-bit decode, registered read-before-write.
        always @(posedge sys_clock) begin
            if (lane_if.mem_w_en) begin
                mem_q[lane_if.mem_addr[14:0]] <= lane_if.mem_wdata;
                wr_q[lane_if.mem_addr[14:0]]  <= 1'b1;
            end
            rd_q <= wr_q[lane_if.mem_addr[14:0]] ? mem_q[lane_if.mem_addr[14:0]]
                                                  : init_word(lane_if.mem_addr[14:0]);
        end
    end

    // Reference model: a grant at cycle g means access at g+1 and ack at g+2.
    int          cyc;
    int          g_cyc    [NL];
    int          streak   [NL];
    bit          m_dma    [NL];
    bit          m_we     [NL];
    bit          m_unk    [NL];
    logic [15:0] m_rd     [NL];
    logic [15:0] last_addr[NL];
    logic [15:0] last_wd  [NL];
    logic [15:0] rmem     [NL][32768];
    bit          unk      [NL][32768];
    byte         obs      [NL][$];
    int          vectors;
    int          miscompares;

    task automatic cmp(input string name, input int l, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s lane%0d cycle %0d: got %h expected %h", name, l, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int          cur;
        bit          dwin;
        logic [14:0] a;
        cur = cyc;
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (sys_reset) begin
                // A write aborted in its access cycle leaves the location undefined.
                if (cur == g_cyc[l] + 1 && m_we[l]) unk[l][last_addr[l][14:0]] = 1'b1;
                g_cyc[l]     = -100;
                streak[l]    = 0;
                last_addr[l] = 16'h0;
                last_wd[l]   = 16'h0;
            end else if (cur >= g_cyc[l] + 3 && (creq[l] || dreq[l])) begin
                dwin = dreq[l] && (!creq[l] || streak[l] >= lim_of(l));
                if (dwin || !dreq[l]) streak[l] = 0;
                else if (streak[l] < lim_of(l)) streak[l]++;
                g_cyc[l]     = cur;
                m_dma[l]     = dwin;
                m_we[l]      = dwin ? dwe[l] : cwe[l];
                last_addr[l] = dwin ? daddr[l] : caddr[l];
                last_wd[l]   = dwin ? dwd[l] : cwd[l];
                a = last_addr[l][14:0];
                if (m_we[l]) begin
                    rmem[l][a] = last_wd[l];
                    unk[l][a]  = 1'b0;
                end else begin
                    m_rd[l]  = rmem[l][a];
                    m_unk[l] = unk[l][a];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int l = 0; l < NL; l++) begin
            logic rst, acc, rsp;
            rst = sys_reset;
            acc = !rst && (cyc == g_cyc[l] + 1);
            rsp = !rst && (cyc == g_cyc[l] + 2);
            cmp("busy", l, {15'd0, bsy[l]}, {15'd0, acc || rsp});
            cmp("mem_w_en", l, {15'd0, mwe[l]}, {15'd0, acc && m_we[l]});
            cmp("mem_addr", l, maddr[l], rst ? 16'h0 : last_addr[l]);
            cmp("mem_wdata", l, mwd[l], rst ? 16'h0 : last_wd[l]);
            cmp("cpu_ack", l, {15'd0, cack[l]}, {15'd0, rsp && !m_dma[l]});
            cmp("dma_ack", l, {15'd0, dack[l]}, {15'd0, rsp && m_dma[l]});
            if (rst || rsp) begin
                if (rst || m_dma[l]) cmp("cpu_rdata", l, crd[l], 16'h0);
                else if (!m_we[l] && !m_unk[l]) cmp("cpu_rdata", l, crd[l], m_rd[l]);
                if (rst || !m_dma[l]) cmp("dma_rdata", l, drd[l], 16'h0);
                else if (!m_we[l] && !m_unk[l]) cmp("dma_rdata", l, drd[l], m_rd[l]);
            end
            if (cack[l] === 1'b1) obs[l].push_back(ChC);
            if (dack[l] === 1'b1) obs[l].push_back(ChD);
        end
    endtask

    task automatic tick();
        @(posedge sys_clock);
        model_step();
        @(negedge sys_clock);
        check_all();
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd);
        for (int l = 0; l < NL; l++) begin
            creq[l] = req; cwe[l] = we; caddr[l] = addr; cwd[l] = wd;
        end
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wd);
        for (int l = 0; l < NL; l++) begin
            dreq[l] = req; dwe[l] = we; daddr[l] = addr; dwd[l] = wd;
        end
    endtask

    task automatic reset_pulse();
        sys_reset = 1'b1;
        #1 check_all();
        tick();
        sys_reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        if ($urandom_range(0, 7) == 0) return 16'h7FFF;
        a = 16'($urandom_range(0, 15));
        a[15] = 1'($urandom_range(0, 1));
        return a;
    endfunction

    initial begin
        string exp0;
        bit    rst_now;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        exp0 = "CCCCDCCCCD";
        for (int l = 0; l < NL; l++) begin
            g_cyc[l] = -100; streak[l] = 0; m_dma[l] = 0; m_we[l] = 0; m_unk[l] = 0;
            m_rd[l] = 16'h0; last_addr[l] = 16'h0; last_wd[l] = 16'h0;
            for (int i = 0; i < 32768; i++) begin
                rmem[l][i] = init_word(15'(i));
                unk[l][i]  = 1'b0;
            end
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) tick();
        sys_reset = 1'b0;
        tick();

        // Single CPU read of 0x0010.
        set_cpu(1'b1, 1'b0, 16'h0010, 16'h5555);
        tick();
        for (int l = 0; l < NL; l++) begin
            cmp("lit_rd_addr", l, maddr[l], 16'h0010);
            cmp("lit_rd_wen", l, {15'd0, mwe[l]}, 16'h0);
            cmp("lit_rd_busy", l, {15'd0, bsy[l]}, 16'h1);
        end
        tick();
        for (int l = 0; l < NL; l++) begin
            cmp("lit_rd_ack", l, {15'd0, cack[l]}, 16'h1);
            cmp("lit_rd_data", l, crd[l], 16'hBEEF);
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // DMA write of 0x1234 to 0x7FFF, then read back.
        set_dma(1'b1, 1'b1, 16'h7FFF, 16'h1234);
        tick();
        for (int l = 0; l < NL; l++) begin
            cmp("lit_wr_wen", l, {15'd0, mwe[l]}, 16'h1);
            cmp("lit_wr_addr", l, maddr[l], 16'h7FFF);
            cmp("lit_wr_data", l, mwd[l], 16'h1234);
        end
        tick();
        for (int l = 0; l < NL; l++) begin
            cmp("lit_wr_ack", l, {15'd0, dack[l]}, 16'h1);
            cmp("lit_wr_wen_off", l, {15'd0, mwe[l]}, 16'h0);
        end
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        set_dma(1'b1, 1'b0, 16'h7FFF, 16'h0);
        repeat (2) tick();
        for (int l = 0; l < NL; l++) cmp("lit_rb_data", l, drd[l], 16'h1234);
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // Continuous contention from a fresh streak.
        reset_pulse();
        for (int l = 0; l < NL; l++) obs[l].delete();
        set_cpu(1'b1, 1'b0, 16'h0003, 16'h0);
        set_dma(1'b1, 1'b0, 16'h0004, 16'h0);
        repeat (30) tick();
        for (int i = 0; i < 10; i++) begin
            cmp("lit_order_lim4", 0, (i < obs[0].size()) ? {8'h0, obs[0][i]} : 16'h0,
                {8'h0, exp0[i]});
            cmp("lit_order_lim0", 1, (i < obs[1].size()) ? {8'h0, obs[1][i]} : 16'h0,
                {8'h0, ChD});
        end
        set_dma(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) tick();
        cmp("lit_lim0_cpu_served", 1, (obs[1].size() == 11) ? {8'h0, obs[1][10]} : 16'h0,
            {8'h0, ChC});
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // Reset during ACCESS of a CPU read aborts it; the retry is served normally.
        set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
        tick();
        set_cpu(1'b0, 1'b0, 16'h0010, 16'h0);
        reset_pulse();
        repeat (3) tick();
        set_cpu(1'b1, 1'b0, 16'h0010, 16'h0);
        repeat (2) tick();
        for (int l = 0; l < NL; l++) begin
            cmp("lit_retry_ack", l, {15'd0, cack[l]}, 16'h1);
            cmp("lit_retry_data", l, crd[l], 16'hBEEF);
        end
        set_cpu(1'b0, 1'b0, 16'h0, 16'h0);
        tick();

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            rst_now = 1'b0;
            if (sys_reset) sys_reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst_now = 1'b1;
            for (int l = 0; l < NL; l++) begin
                if (cack[l]) creq[l] = 1'($urandom_range(0, 1));
                else if (!creq[l]) creq[l] = ($urandom_range(0, 2) == 0);
                if (dack[l]) dreq[l] = 1'($urandom_range(0, 1));
                else if (!dreq[l]) dreq[l] = ($urandom_range(0, 2) == 0);
                cwe[l] = 1'($urandom_range(0, 1));
                dwe[l] = 1'($urandom_range(0, 1));
                caddr[l] = rand_addr();
                daddr[l] = rand_addr();
                cwd[l] = 16'($urandom);
                dwd[l] = 16'($urandom);
            end
            if (rst_now) begin
                sys_reset = 1'b1;
                #1 check_all();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port request/acknowledge arbiter in front of the single-port synchronous data memory (16-bit words, 1-cycle registered read).
- Shares the memory between the CPU load/store path and the DMA/video blitter path.
- Owns the memory control signals: latches the winning request, issues one access, and returns an ack together with the read data.
- CPU has priority, bounded by a starvation limit so DMA is always guaranteed progress.

Parameters:
STARVE_LIMIT, 4, max consecutive CPU grants while DMA is waiting; 0 = DMA wins every contention
CNT_W, $clog2(STARVE_LIMIT+1) (min 1), width of the CPU streak counter

Ports:
sys_clock  in  1  system clock, rising edge
sys_reset  in  1  asynchronous active-high reset
cpu_req  in  1  CPU request, held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  16  CPU word address
cpu_wdata  in  16  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  16  read data, valid only while cpu_ack=1
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  DMA write / read
dma_addr  in  16  DMA word address
dma_wdata  in  16  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  16  read data, valid only while dma_ack=1
mem_w_en  out  1  to memory write enable
mem_addr  out  16  to memory address (memory decodes [14:0]; passed unmodified)
mem_wdata  out  16  to memory write data
mem_rdata  in  16  from memory read data (1-cycle latency)
busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset (async, immediate): state=IDLE, owner=CPU, streak=0; all outputs 0, including mem_w_en, mem_addr, mem_wdata, both acks and both rdata.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle; no back-to-back pipelining.
- IDLE, no request: stay in IDLE; mem_w_en=0.
- IDLE, any request: pick the winner; register owner, mem_addr, mem_wdata, and mem_w_en=winner_we; go to ACCESS.
- ACCESS: memory port registers are stable. The memory samples the access at the end of this cycle. mem_w_en drops to 0 on the edge leaving ACCESS; mem_addr holds.
- RESP: assert owner's ack for one cycle (registered). Owner's rdata = mem_rdata combinationally; the other rdata = 0. Writes also ack; rdata on a write ack = mem_rdata, which bench ignores. Next state IDLE.
- Latency: req first sampled high in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2. Throughput is 1 access per 3 cycles.
- Requester contract: drop req in the cycle after ack. req still high in the next IDLE counts as a new request. Request inputs changing during ACCESS or RESP are ignored; fields were latched in IDLE.
- Arbitration (in IDLE only):
  - Only one requester: that one wins.
  - Both requesting: DMA wins if streak >= STARVE_LIMIT, otherwise CPU wins.
- Streak update on each grant:
  - CPU grant while dma_req=1: streak+1, saturating at STARVE_LIMIT.
  - DMA grant, or CPU grant with dma_req=0: streak=0.
- Reset during ACCESS or RESP: transaction aborted, no ack issued, mem_w_en=0 at once. A write in flight may or may not land; software must not rely on it.
- Address bit 15 is forwarded untouched; aliasing is the memory's concern.
- Never assert both acks in the same cycle; never assert an ack outside RESP.

Test Plan:
- Reset: assert sys_reset mid-run with random inputs -> all outputs 0 in the same cycle; first access after release is served normally.
- Single CPU read: memory preloaded with 0xBEEF at 0x0010; cpu_req at cycle N (read, addr 0x0010) -> mem_w_en stays 0, mem_addr=0x0010 at N+1, cpu_ack=1 and cpu_rdata=0xBEEF at N+2, busy high N+1..N+2.
- Write then read-back: DMA writes 0x1234 to 0x7FFF (mem_w_en=1 only in ACCESS), dma_ack at N+2; DMA reads 0x7FFF -> dma_rdata=0x1234.
- Contention, STARVE_LIMIT=4: cpu_req and dma_req held continuously, each re-requesting after its ack -> grant order C,C,C,C,D,C,C,C,C,D; never two acks in one cycle.
- STARVE_LIMIT=0: continuous contention -> DMA wins every grant; CPU is served only when dma_req=0.
- Mid-transaction reset: reset pulse during ACCESS of a CPU read -> no cpu_ack; after release, CPU re-requests and is acked 2 cycles after being sampled.
